led_matrix_scan: RTL and testbench



---
 rtl/led_matrix_scan.sv | 129 ++++++++++++
 tb/tb_led_matrix_scan.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan.sv
// Multiplexed ROWS x COLS LED scanner with per-frame shadow and blanking.
// Define LED_SCAN_PWM_EN to compile in global PWM brightness.
module led_matrix_scan #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DWELL    = 32,
  parameter int BLANK    = 2,
  parameter int BRIGHT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS*COLS-1:0] ledbits,
  input  logic [BRIGHT_W-1:0]  brightness,
  output logic [ROWS-1:0]      aled,
  output logic [COLS-1:0]      kled_tri,
  output logic                 frame_start
);

  localparam int N    = ROWS * COLS;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int KMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int KW   = (KMAX > 1) ? $clog2(KMAX) : 1;

  localparam logic [KW-1:0] BL_LAST  = KW'(BLANK - 1);
  localparam logic [KW-1:0] DW_LAST  = KW'(DWELL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic {
    S_BLANK,
    S_ON
  } state_t;

  state_t         state;
  logic [KW-1:0]  cnt;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic [IW-1:0]  idx;
  logic [N-1:0]   shadow;
  logic           pwm_on;
  logic           lit;

`ifdef LED_SCAN_PWM_EN
  localparam int MAXB = (2 ** BRIGHT_W) - 1;
  localparam int DW_B = (DWELL > 1) ? $clog2(DWELL) : 0;
  localparam int PW   = DW_B + BRIGHT_W + 1;

  logic [BRIGHT_W-1:0] bright;
  logic [PW-1:0]       prod_k;
  logic [PW-1:0]       prod_b;

  assign prod_k = PW'(cnt) * PW'(MAXB);
  assign prod_b = PW'(bright) * PW'(DWELL);
  assign pwm_on = (prod_k < prod_b);
`else
  logic unused_bright;

  assign unused_bright = ^brightness;
  assign pwm_on        = 1'b1;
`endif

  assign lit = shadow[idx] & pwm_on;

  // state describes the output cycle produced at the coming edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_BLANK;
      cnt         <= '0;
      row         <= '0;
      col         <= '0;
      idx         <= '0;
      shadow      <= '0;
      aled        <= '1;
      kled_tri    <= '0;
      frame_start <= 1'b0;
`ifdef LED_SCAN_PWM_EN
      bright      <= '0;
`endif
    end else begin
      frame_start <= 1'b0;
      unique case (state)
        S_BLANK: begin
          aled     <= '1;
          kled_tri <= '0;
          if (cnt == '0 && idx == '0) begin
            shadow      <= ledbits;
            frame_start <= 1'b1;
`ifdef LED_SCAN_PWM_EN
            bright      <= brightness;
`endif
          end
          if (cnt == BL_LAST) begin
            cnt   <= '0;
            state <= S_ON;
          end else begin
            cnt <= cnt + KW'(1);
          end
        end
        S_ON: begin
          aled     <= ~(ROWS'(1) << row);
          kled_tri <= lit ? (COLS'(1) << col) : '0;
          if (cnt == DW_LAST) begin
            cnt   <= '0;
            state <= S_BLANK;
            if (idx == IDX_LAST) begin
              idx <= '0;
              row <= '0;
              col <= '0;
            end else begin
              idx <= idx + IW'(1);
              if (row == ROW_LAST) begin
                row <= '0;
                col <= col + CW'(1);
              end else begin
                row <= row + RW'(1);
              end
            end
          end else begin
            cnt <= cnt + KW'(1);
          end
        end
        default: state <= S_BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan: default 4x4 instance plus a 2x3 one.
// Expected outputs come from a cycle model keyed on position in frame.
module tb_led_matrix_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ledbits;
  logic [3:0]  brightness;
  logic [3:0]  aled;
  logic [3:0]  kled_tri;
  logic        frame_start;
  logic [5:0]  s_ledbits;
  logic [1:0]  s_aled;
  logic [2:0]  s_kled;
  logic        s_fs;

  int n_cmp = 0;
  int n_bad = 0;
  int t;
  int lit;
  int first;
  logic [3:0]  kor;
  logic [15:0] msh;
  logic [3:0]  mbr;

  always #5 clk = ~clk;

  led_matrix_scan dut (
    .clk(clk), .rst(rst), .ledbits(ledbits),
    .brightness(brightness), .aled(aled),
    .kled_tri(kled_tri), .frame_start(frame_start)
  );

  led_matrix_scan #(
    .ROWS(2), .COLS(3), .DWELL(4), .BLANK(1)
  ) dut_s (
    .clk(clk), .rst(rst), .ledbits(s_ledbits),
    .brightness(brightness), .aled(s_aled),
    .kled_tri(s_kled), .frame_start(s_fs)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%h exp=%h",
               tag, t, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pwm(int k, logic [3:0] b);
`ifdef LED_SCAN_PWM_EN
    return (k * 15) < (int'(b) * 32);
`else
    return 1'b1;
`endif
  endfunction

  task automatic step();
    logic [15:0] lb;
    logic [3:0]  br;
    logic [8:0]  e;
    logic [5:0]  es;
    int pos, slot, ph;
    lb = ledbits;
    br = brightness;
    tick();
    t++;
    pos  = t % 544;
    slot = pos / 34;
    ph   = pos % 34;
    if (pos == 0) begin
      msh = lb;
      mbr = br;
    end
    e = '0;
    e[8] = (pos == 0);
    if (ph < 2) begin
      e[7:4] = 4'hF;
    end else begin
      e[7:4] = ~(4'b0001 << (slot % 4));
      if (msh[slot] && pwm(ph - 2, mbr))
        e[3:0] = 4'b0001 << (slot / 4);
    end
    check("main", {frame_start, aled, kled_tri}, e);
    if (kled_tri != 0) begin
      lit++;
      kor |= kled_tri;
      if (first < 0) first = pos;
    end
    pos = t % 30;
    es = '0;
    es[5] = (pos == 0);
    if (pos % 5 == 0) begin
      es[4:3] = 2'b11;
    end else begin
      es[4:3] = ~(2'b01 << ((pos / 5) % 2));
      es[2:0] = 3'b001 << ((pos / 5) / 2);
    end
    check("small", {s_fs, s_aled, s_kled}, es);
  endtask

  task automatic frame();
    lit   = 0;
    first = -1;
    kor   = '0;
    for (int i = 0; i < 544; i++) step();
  endtask

  initial begin
    rst        = 1'b1;
    ledbits    = 16'hFFFF;
    s_ledbits  = 6'b111111;
    brightness = 4'd15;
    t          = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_hold", {frame_start, aled, kled_tri},
            {1'b0, 4'hF, 4'h0});
      check("rst_hold_s", {s_fs, s_aled, s_kled},
            {1'b0, 2'b11, 3'b000});
    end

    ledbits = 16'h0020;
    rst     = 1'b0;
    for (int f = 0; f < 2; f++) begin
      frame();
      check("single_cnt", lit, 32);
      check("single_ofs", first, 172);
      check("single_k", kor, 4'b0010);
    end

    ledbits = 16'h0001;
    lit = 0; first = -1; kor = '0;
    for (int i = 0; i < 544; i++) begin
      if (i == 100) ledbits = 16'h8000;
      step();
    end
    check("tear_cnt", lit, 32);
    check("tear_k", kor, 4'b0001);
    frame();
    check("next_cnt", lit, 32);
    check("next_k", kor, 4'b1000);
    check("next_ofs", first, 15 * 34 + 2);

    ledbits    = 16'h0001;
    brightness = 4'd8;
    frame();
`ifdef LED_SCAN_PWM_EN
    check("pwm8", lit, 18);
`else
    check("pwm8", lit, 32);
`endif
    brightness = 4'd15;
    frame();
    check("pwm15", lit, 32);
    brightness = 4'd0;
    frame();
`ifdef LED_SCAN_PWM_EN
    check("pwm0", lit, 0);
`else
    check("pwm0", lit, 32);
`endif

    brightness = 4'd15;
    ledbits    = 16'h0080;
    lit = 0; first = -1; kor = '0;
    for (int i = 0; i < 7 * 34 + 11; i++) step();
    check("pre_rst_k", kor, 4'b0010);
    ledbits = 16'h0002;
    rst     = 1'b1;
    tick();
    check("mid_rst", {frame_start, aled, kled_tri},
          {1'b0, 4'hF, 4'h0});
    check("mid_rst_s", {s_fs, s_aled, s_kled},
          {1'b0, 2'b11, 3'b000});
    rst = 1'b0;
    t   = -1;
    frame();
    check("restart_cnt", lit, 32);
    check("restart_ofs", first, 36);
    check("restart_k", kor, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
